// File: rtl/isp_gamma_lut_bank_if.sv
// isp_gamma_lut_bank_if: pixel stream and configuration bus of the gamma LUT bank.
// The readback signals exist only when GAMMA_LUT_READBACK_EN is defined.
interface isp_gamma_lut_bank_if #(
    parameter int BITS     = 8,
    parameter int CHANNELS = 3,
    parameter int LUT_BITS = 8
);
    localparam int CHAN_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    // pixel stream
    logic                       in_href;
    logic                       in_vsync;
    logic [CHANNELS*BITS-1:0]   in_data;
    logic                       out_href;
    logic                       out_vsync;
    logic [CHANNELS*BITS-1:0]   out_data;

    // table configuration
    logic                       cfg_wen;
    logic [CHAN_W-1:0]          cfg_chan;
    logic [LUT_BITS-1:0]        cfg_addr;
    logic [BITS-1:0]            cfg_wdata;
    logic                       cfg_commit;
    logic                       cfg_busy;
    logic                       bank_sel;
    logic                       init_done;
`ifdef GAMMA_LUT_READBACK_EN
    logic                       cfg_ren;
    logic [BITS-1:0]            cfg_rdata;
    logic                       cfg_rvalid;
`endif

    modport master (
        output in_href, in_vsync, in_data,
        output cfg_wen, cfg_chan, cfg_addr, cfg_wdata, cfg_commit,
`ifdef GAMMA_LUT_READBACK_EN
        output cfg_ren,
        input  cfg_rdata, cfg_rvalid,
`endif
        input  out_href, out_vsync, out_data,
        input  cfg_busy, bank_sel, init_done
    );

    modport slave (
        input  in_href, in_vsync, in_data,
        input  cfg_wen, cfg_chan, cfg_addr, cfg_wdata, cfg_commit,
`ifdef GAMMA_LUT_READBACK_EN
        input  cfg_ren,
        output cfg_rdata, cfg_rvalid,
`endif
        output out_href, out_vsync, out_data,
        output cfg_busy, bank_sel, init_done
    );
endinterface

// File: rtl/isp_gamma_lut_bank.sv
// isp_gamma_lut_bank: double-buffered, per-channel programmable gamma LUT.
// Tables self-initialise to an identity ramp after reset, software loads the
// shadow bank, and a commit swaps banks on the next vsync rising edge.
// Pixel path latency is 2 cycles; bypass (delayed input) until init completes.
// Optional macro GAMMA_LUT_READBACK_EN adds shadow-bank readback
// (cfg_ren / cfg_rdata / cfg_rvalid, 2-cycle read latency).
module isp_gamma_lut_bank #(
    parameter int BITS     = 8,
    parameter int CHANNELS = 3,
    parameter int LUT_BITS = 8
) (
    input  logic                 pclk,
    input  logic                 rst_n,
    isp_gamma_lut_bank_if.slave  bus
);
    localparam int DEPTH  = 1 << LUT_BITS;
    localparam int CHAN_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int DW     = CHANNELS * BITS;

    localparam logic [1:0] ST_INIT = 2'd0;
    localparam logic [1:0] ST_IDLE = 2'd1;
    localparam logic [1:0] ST_PEND = 2'd2;

    logic [1:0]          state;
    logic [LUT_BITS-1:0] init_addr;
    logic                init_done_q;
    logic                bank_sel_q;
    logic                prev_vsync;

    logic                vs_rise;
    logic                is_idle;
    logic                swap_now;
    logic                chan_ok;
    logic                wr_en;
    logic                rd_bank;
    logic [BITS-1:0]     ramp_val;

    logic [BITS-1:0]     mem [2][CHANNELS][DEPTH];
    logic [BITS-1:0]     ram_q [CHANNELS];
    logic [DW-1:0]       lut_word;

    logic                href_d1;
    logic                vsync_d1;
    logic [DW-1:0]       data_d1;
    logic                lut_d1;
    logic                out_href_q;
    logic                out_vsync_q;
    logic [DW-1:0]       out_data_q;

`ifdef GAMMA_LUT_READBACK_EN
    logic                rd_req;
    logic                rd_v1;
    logic [BITS-1:0]     rd_q;
    logic                cfg_rvalid_q;
    logic [BITS-1:0]     cfg_rdata_q;
`endif

    // Control decodes: frame-boundary edge, shadow write qualification, read bank, init ramp value
    always_comb begin
        vs_rise  = bus.in_vsync & ~prev_vsync;
        is_idle  = (state == ST_IDLE);
        swap_now = (state == ST_PEND) & vs_rise;
        chan_ok  = ({1'b0, bus.cfg_chan} < (CHAN_W+1)'(CHANNELS));
        wr_en    = is_idle & bus.cfg_wen & chan_ok;
        // A pixel arriving in the swap cycle already uses the new bank,
        // so no pixel ever straddles the two tables.
        rd_bank  = bank_sel_q ^ swap_now;
        ramp_val = BITS'(init_addr) << (BITS - LUT_BITS);
`ifdef GAMMA_LUT_READBACK_EN
        rd_req   = is_idle & bus.cfg_ren & ~bus.cfg_wen & chan_ok;
`endif
    end

    // Bank-control FSM: identity init, shadow loading, swap on vsync rising edge
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_INIT;
            init_addr   <= '0;
            init_done_q <= 1'b0;
            bank_sel_q  <= 1'b0;
            prev_vsync  <= 1'b0;
        end else begin
            prev_vsync <= bus.in_vsync;
            case (state)
                ST_INIT: begin
                    init_addr <= init_addr + 1'b1;
                    if (init_addr == '1) begin
                        state       <= ST_IDLE;
                        init_done_q <= 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (bus.cfg_commit) begin
                        state <= ST_PEND;
                    end
                end
                ST_PEND: begin
                    if (vs_rise) begin
                        bank_sel_q <= ~bank_sel_q;
                        state      <= ST_IDLE;
                    end
                end
                default: state <= ST_INIT;
            endcase
        end
    end

    // Table RAMs: parallel ramp fill during init, shadow writes, synchronous pixel reads
    always_ff @(posedge pclk) begin
        if (state == ST_INIT) begin
            for (int unsigned c = 0; c < CHANNELS; c++) begin
                mem[0][c][init_addr] <= ramp_val;
                mem[1][c][init_addr] <= ramp_val;
            end
        end else if (wr_en) begin
            mem[~bank_sel_q][bus.cfg_chan][bus.cfg_addr] <= bus.cfg_wdata;
        end
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            ram_q[c] <= mem[rd_bank][c][bus.in_data[c*BITS+BITS-1 -: LUT_BITS]];
        end
`ifdef GAMMA_LUT_READBACK_EN
        if (rd_req) begin
            rd_q <= mem[~bank_sel_q][bus.cfg_chan][bus.cfg_addr];
        end
`endif
    end

    // Pack per-channel RAM outputs into one pixel word
    always_comb begin
        lut_word = '0;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            lut_word[c*BITS +: BITS] = ram_q[c];
        end
    end

    // Two-stage pixel pipeline: stage 1 alongside the RAM read, stage 2 selects LUT/bypass and gates by href
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            href_d1     <= 1'b0;
            vsync_d1    <= 1'b0;
            data_d1     <= '0;
            lut_d1      <= 1'b0;
            out_href_q  <= 1'b0;
            out_vsync_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            href_d1     <= bus.in_href;
            vsync_d1    <= bus.in_vsync;
            data_d1     <= bus.in_data;
            lut_d1      <= init_done_q;
            out_href_q  <= href_d1;
            out_vsync_q <= vsync_d1;
            if (!href_d1) begin
                out_data_q <= '0;
            end else if (lut_d1) begin
                out_data_q <= lut_word;
            end else begin
                out_data_q <= data_d1;
            end
        end
    end

`ifdef GAMMA_LUT_READBACK_EN
    // Readback response: valid pulse and data two cycles after an accepted request
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            rd_v1        <= 1'b0;
            cfg_rvalid_q <= 1'b0;
            cfg_rdata_q  <= '0;
        end else begin
            rd_v1        <= rd_req;
            cfg_rvalid_q <= rd_v1;
            if (rd_v1) begin
                cfg_rdata_q <= rd_q;
            end
        end
    end

    assign bus.cfg_rvalid = cfg_rvalid_q;
    assign bus.cfg_rdata  = cfg_rdata_q;
`endif

    assign bus.out_href  = out_href_q;
    assign bus.out_vsync = out_vsync_q;
    assign bus.out_data  = out_data_q;
    assign bus.cfg_busy  = (state != ST_IDLE);
    assign bus.bank_sel  = bank_sel_q;
    assign bus.init_done = init_done_q;

endmodule

// File: tb/tb_isp_gamma_lut_bank.sv
// tb_isp_gamma_lut_bank: directed vector table plus randomized traffic against
// a table-array reference model of isp_gamma_lut_bank.
module tb_isp_gamma_lut_bank;
    localparam int BITS  = 8;
    localparam int CH    = 3;
    localparam int LB    = 8;
    localparam int CW    = 2;
    localparam int DW    = CH * BITS;
    localparam int DEPTH = 1 << LB;

    logic pclk = 1'b0;
    logic rst_n = 1'b0;
    logic m_ren = 1'b0;

    always #5 pclk = ~pclk;

    isp_gamma_lut_bank_if #(.BITS(BITS), .CHANNELS(CH), .LUT_BITS(LB)) bus ();

    isp_gamma_lut_bank #(.BITS(BITS), .CHANNELS(CH), .LUT_BITS(LB)) dut (
        .pclk  (pclk),
        .rst_n (rst_n),
        .bus   (bus)
    );

`ifdef GAMMA_LUT_READBACK_EN
    assign bus.cfg_ren = m_ren;
`endif

    typedef struct {
        logic            href;
        logic            vs;
        logic [DW-1:0]   data;
        logic            rv;
        logic [BITS-1:0] rd;
    } exp_t;

    typedef struct {
        logic            href;
        logic            vs;
        logic [DW-1:0]   data;
        logic            wen;
        logic [CW-1:0]   chan;
        logic [LB-1:0]   addr;
        logic [BITS-1:0] wdata;
        logic            commit;
        logic            chk;
        logic [DW-1:0]   exp;
        logic            exp_bank;
        logic            exp_busy;
    } vec_t;

    // reference model state
    exp_t            pipe[$];
    logic [BITS-1:0] tbl [2][CH][DEPTH];
    bit              m_bank, m_pend, m_init, m_prev_vs;
    int              m_cycles;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int b = 0; b < 2; b++)
            for (int c = 0; c < CH; c++)
                for (int i = 0; i < DEPTH; i++)
                    tbl[b][c][i] = BITS'(i << (BITS - LB));
        m_bank = 1'b0; m_pend = 1'b0; m_init = 1'b0; m_prev_vs = 1'b0; m_cycles = 0;
        pipe.delete();
        pipe.push_back('{default: '0});
    endfunction

    task automatic drive(input logic href, input logic vs, input logic [DW-1:0] data,
                         input logic wen, input logic [CW-1:0] chan, input logic [LB-1:0] addr,
                         input logic [BITS-1:0] wdata, input logic commit, input logic ren);
        bus.in_href    = href;
        bus.in_vsync   = vs;
        bus.in_data    = data;
        bus.cfg_wen    = wen;
        bus.cfg_chan   = chan;
        bus.cfg_addr   = addr;
        bus.cfg_wdata  = wdata;
        bus.cfg_commit = commit;
        m_ren          = ren;
    endtask

    task automatic drive_idle();
        drive(1'b0, 1'b0, '0, 1'b0, '0, '0, '0, 1'b0, 1'b0);
    endtask

    // One clock: predict from current inputs, advance the model, compare after the edge
    task automatic tick();
        exp_t            e, due;
        bit              rise, idle, wb;
        int              ch;
        logic [BITS-1:0] pix;
        rise = bus.in_vsync && !m_prev_vs;
        e = '{default: '0};
        e.href = bus.in_href;
        e.vs   = bus.in_vsync;
        if (bus.in_href) begin
            if (!m_init) begin
                e.data = bus.in_data;
            end else begin
                wb = m_bank ^ (m_pend && rise);
                for (int c = 0; c < CH; c++) begin
                    pix = bus.in_data[c*BITS +: BITS];
                    e.data[c*BITS +: BITS] = tbl[wb][c][pix >> (BITS - LB)];
                end
            end
        end
        idle = m_init && !m_pend;
        ch = int'(bus.cfg_chan);
        if (idle && bus.cfg_wen && ch < CH) begin
            tbl[!m_bank][ch][bus.cfg_addr] = bus.cfg_wdata;
        end else if (idle && m_ren && !bus.cfg_wen && ch < CH) begin
            e.rv = 1'b1;
            e.rd = tbl[!m_bank][ch][bus.cfg_addr];
        end
        if (m_pend && rise) begin
            m_bank = !m_bank;
            m_pend = 1'b0;
        end else if (idle && bus.cfg_commit) begin
            m_pend = 1'b1;
        end
        m_prev_vs = bus.in_vsync;
        m_cycles++;
        if (m_cycles >= DEPTH) m_init = 1'b1;
        pipe.push_back(e);

        @(posedge pclk);
        #1;
        due = pipe.pop_front();
        check("out_href",  64'(bus.out_href),  64'(due.href));
        check("out_vsync", 64'(bus.out_vsync), 64'(due.vs));
        check("out_data",  64'(bus.out_data),  64'(due.data));
        check("bank_sel",  64'(bus.bank_sel),  64'(m_bank));
        check("cfg_busy",  64'(bus.cfg_busy),  64'(!m_init || m_pend));
        check("init_done", 64'(bus.init_done), 64'(m_init));
`ifdef GAMMA_LUT_READBACK_EN
        check("cfg_rvalid", 64'(bus.cfg_rvalid), 64'(due.rv));
        if (due.rv) check("cfg_rdata", 64'(bus.cfg_rdata), 64'(due.rd));
`endif
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_out_href",  64'(bus.out_href),  64'd0);
        check("rst_out_vsync", 64'(bus.out_vsync), 64'd0);
        check("rst_out_data",  64'(bus.out_data),  64'd0);
        check("rst_bank_sel",  64'(bus.bank_sel),  64'd0);
        check("rst_init_done", 64'(bus.init_done), 64'd0);
        check("rst_cfg_busy",  64'(bus.cfg_busy),  64'd1);
`ifdef GAMMA_LUT_READBACK_EN
        check("rst_cfg_rvalid", 64'(bus.cfg_rvalid), 64'd0);
        check("rst_cfg_rdata",  64'(bus.cfg_rdata),  64'd0);
`endif
        repeat (3) @(negedge pclk);
        drive_idle();
        rst_n = 1'b1;
        model_reset();
    endtask

    // Run through INIT with a bypass pixel on the bus; init must take exactly DEPTH cycles
    task automatic run_init(input string name);
        int cnt;
        cnt = 0;
        drive(1'b1, 1'b0, 24'h555555, 1'b1, 2'd0, 8'h80, 8'hEE, 1'b1, 1'b1);
        while (!bus.init_done && cnt < 600) begin
            tick();
            cnt++;
            if (cnt == 3) check({name, "_bypass"}, 64'(bus.out_data), 64'h555555);
        end
        check(name, 64'(cnt), 64'(DEPTH));
    endtask

    // Bring the block to IDLE by completing any pending swap
    task automatic settle();
        drive_idle();
        tick();
        if (m_pend) begin
            drive(1'b0, 1'b1, '0, 1'b0, '0, '0, '0, 1'b0, 1'b0);
            tick();
            drive_idle();
            tick();
        end
    endtask

    vec_t vecs[$];

    initial begin
        //             href  vs    data        wen   chan  addr   wdata  commit chk   exp         bank  busy
        vecs.push_back('{1'b1, 1'b0, 24'h104080, 1'b0, 2'd0, 8'h00, 8'h00, 1'b0, 1'b1, 24'h104080, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 24'h000000, 1'b1, 2'd0, 8'h80, 8'hBA, 1'b0, 1'b0, 24'h000000, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 24'h000000, 1'b0, 2'd0, 8'h00, 8'h00, 1'b1, 1'b0, 24'h000000, 1'b0, 1'b1});
        vecs.push_back('{1'b1, 1'b0, 24'h808080, 1'b0, 2'd0, 8'h00, 8'h00, 1'b0, 1'b1, 24'h808080, 1'b0, 1'b1});
        vecs.push_back('{1'b0, 1'b1, 24'h000000, 1'b0, 2'd0, 8'h00, 8'h00, 1'b0, 1'b0, 24'h000000, 1'b1, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 24'h808080, 1'b0, 2'd0, 8'h00, 8'h00, 1'b0, 1'b1, 24'h8080BA, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 24'h808080, 1'b0, 2'd0, 8'h00, 8'h00, 1'b0, 1'b1, 24'h000000, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 24'h000000, 1'b1, 2'd1, 8'h80, 8'h11, 1'b0, 1'b0, 24'h000000, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 24'h000000, 1'b0, 2'd0, 8'h00, 8'h00, 1'b1, 1'b0, 24'h000000, 1'b1, 1'b1});
        vecs.push_back('{1'b0, 1'b0, 24'h000000, 1'b1, 2'd2, 8'h80, 8'h77, 1'b0, 1'b0, 24'h000000, 1'b1, 1'b1});
        vecs.push_back('{1'b1, 1'b0, 24'h808080, 1'b0, 2'd0, 8'h00, 8'h00, 1'b0, 1'b1, 24'h8080BA, 1'b1, 1'b1});
        vecs.push_back('{1'b0, 1'b1, 24'h000000, 1'b0, 2'd0, 8'h00, 8'h00, 1'b0, 1'b0, 24'h000000, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 24'h808080, 1'b0, 2'd0, 8'h00, 8'h00, 1'b0, 1'b1, 24'h801180, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 24'h000000, 1'b1, 2'd3, 8'h80, 8'h99, 1'b0, 1'b0, 24'h000000, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 24'h000000, 1'b1, 2'd2, 8'h40, 8'h44, 1'b1, 1'b0, 24'h000000, 1'b0, 1'b1});
        vecs.push_back('{1'b0, 1'b1, 24'h000000, 1'b0, 2'd0, 8'h00, 8'h00, 1'b0, 1'b0, 24'h000000, 1'b1, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 24'h404040, 1'b0, 2'd0, 8'h00, 8'h00, 1'b0, 1'b1, 24'h444040, 1'b1, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 24'h808080, 1'b0, 2'd0, 8'h00, 8'h00, 1'b0, 1'b1, 24'h8080BA, 1'b1, 1'b0});

        drive_idle();
        do_reset();
        run_init("init_cycles");

        // directed table: one active cycle, one idle cycle, then compare
        foreach (vecs[i]) begin
            drive(vecs[i].href, vecs[i].vs, vecs[i].data, vecs[i].wen, vecs[i].chan,
                  vecs[i].addr, vecs[i].wdata, vecs[i].commit, 1'b0);
            tick();
            drive_idle();
            tick();
            if (vecs[i].chk)
                check($sformatf("vec%0d_data", i), 64'(bus.out_data), 64'(vecs[i].exp));
            check($sformatf("vec%0d_bank", i), 64'(bus.bank_sel), 64'(vecs[i].exp_bank));
            check($sformatf("vec%0d_busy", i), 64'(bus.cfg_busy), 64'(vecs[i].exp_busy));
        end

        // randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            logic vsn;
            vsn = ($urandom_range(0, 15) == 0) ? ~bus.in_vsync : bus.in_vsync;
            drive(($urandom_range(0, 3) != 0), vsn, DW'($urandom),
                  ($urandom_range(0, 3) == 0), CW'($urandom_range(0, 3)), LB'($urandom),
                  BITS'($urandom), ($urandom_range(0, 40) == 0), ($urandom_range(0, 3) == 0));
            tick();
        end

`ifdef GAMMA_LUT_READBACK_EN
        settle();
        drive(1'b0, 1'b0, '0, 1'b1, 2'd2, 8'd5, 8'h3C, 1'b0, 1'b0);
        tick();
        drive(1'b0, 1'b0, '0, 1'b0, 2'd2, 8'd5, 8'h00, 1'b0, 1'b1);
        tick();
        drive_idle();
        tick();
        check("rb_rvalid", 64'(bus.cfg_rvalid), 64'd1);
        check("rb_rdata",  64'(bus.cfg_rdata),  64'h3C);
        drive(1'b0, 1'b0, '0, 1'b1, 2'd2, 8'd5, 8'h3D, 1'b0, 1'b1);
        tick();
        drive_idle();
        tick();
        check("rb_wen_ren_rvalid", 64'(bus.cfg_rvalid), 64'd0);
        drive(1'b0, 1'b0, '0, 1'b0, 2'd2, 8'd5, 8'h00, 1'b0, 1'b1);
        tick();
        drive_idle();
        tick();
        check("rb_after_write", 64'(bus.cfg_rdata), 64'h3D);
`endif

        // reset mid-line after a swap
        settle();
        if (!m_bank) begin
            drive(1'b0, 1'b0, '0, 1'b0, '0, '0, '0, 1'b1, 1'b0);
            tick();
            drive_idle();
            tick();
            drive(1'b0, 1'b1, '0, 1'b0, '0, '0, '0, 1'b0, 1'b0);
            tick();
        end
        check("pre_reset_bank", 64'(bus.bank_sel), 64'd1);
        drive(1'b1, 1'b0, 24'h808080, 1'b0, '0, '0, '0, 1'b0, 1'b0);
        tick();
        tick();
        #2;
        do_reset();
        run_init("reinit_cycles");
        drive(1'b1, 1'b0, 24'h808080, 1'b0, '0, '0, '0, 1'b0, 1'b0);
        tick();
        drive_idle();
        tick();
        check("post_reset_identity", 64'(bus.out_data), 64'h808080);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/isp_gamma_lut_bank.md
Name: isp_gamma_lut_bank

Overview:
Programmable, double-buffered, multi-channel gamma look-up stage for the ISP YUV/RGB path. It replaces the fixed gamma case table with per-channel RAM tables that are auto-initialised to an identity ramp at reset. Tables are loaded at run time through a config port into a shadow bank and swapped into use only at a frame boundary. It sits after CCM/CSC and before 2DNR/EE in the pipeline.

Parameters:
BITS, 8, pixel and table-entry width per channel
CHANNELS, 3, number of independent channels/tables (1..4)
LUT_BITS, 8, table index width; depth = 2^LUT_BITS; must satisfy LUT_BITS <= BITS

Ports:
pclk  input  1  pixel clock; only clock
rst_n  input  1  asynchronous active-low reset
in_href  input  1  line valid
in_vsync  input  1  frame sync; a rising edge marks the frame boundary
in_data  input  CHANNELS*BITS  channel c occupies [c*BITS +: BITS]
out_href  output  1  in_href delayed 2 cycles
out_vsync  output  1  in_vsync delayed 2 cycles
out_data  output  CHANNELS*BITS  gamma-mapped pixel
cfg_wen  input  1  table write strobe
cfg_chan  input  max(1,$clog2(CHANNELS))  target channel
cfg_addr  input  LUT_BITS  table index
cfg_wdata  input  BITS  entry value
cfg_commit  input  1  request bank swap at next frame boundary
cfg_busy  output  1  high during INIT or PENDING; writes ignored while high
bank_sel  output  1  active bank index
init_done  output  1  high once the identity ramp is loaded

Behaviour:
- Reset values: out_href=0, out_vsync=0, out_data=0, bank_sel=0, init_done=0, cfg_busy=1. The FSM enters INIT.
- Storage: 2 banks x CHANNELS x 2^LUT_BITS x BITS, using synchronous-read RAM.
- FSM states:
  - INIT: an address counter runs 0..2^LUT_BITS-1 at one entry per cycle. It writes ramp(i) = {i, (BITS-LUT_BITS) zeros} to every channel of both banks in parallel. After the last address the FSM goes to IDLE, sets init_done=1 and cfg_busy=0. INIT lasts exactly 2^LUT_BITS cycles.
  - IDLE: cfg_wen writes cfg_wdata to shadow bank (~bank_sel), channel cfg_chan, at cfg_addr. A cfg_chan >= CHANNELS write is dropped. cfg_commit moves the FSM to PENDING and raises cfg_busy.
  - PENDING: the FSM waits for a rising edge of in_vsync, detected as in_vsync & ~prev_vsync with prev_vsync registered. On that edge bank_sel toggles and the FSM returns to IDLE with cfg_busy=0.
- Boundary conditions:
  - cfg_commit in the same cycle as a vsync rising edge: the FSM enters PENDING; the swap happens on the next rising edge, never the current one.
  - cfg_commit while PENDING or INIT: ignored. cfg_wen while busy: ignored.
  - cfg_wen and cfg_commit in the same IDLE cycle: the write is performed, then the FSM moves to PENDING.
  - After a swap, the new shadow bank holds the previous active table. Software rewrites every entry it needs before the next commit.
- Datapath, 2-cycle latency:
  - Cycle 1: index = in_data[c*BITS+BITS-1 -: LUT_BITS], read from bank_sel.
  - Cycle 2: the RAM output is registered to out_data.
- bank_sel is sampled with the index in cycle 1. A swap therefore affects pixels entering on or after the swap cycle. It never splits a pixel between banks.
- out_data=0 whenever the delayed href is low.
- While init_done=0, out_data = in_data delayed 2 cycles (bypass), gated by the delayed href.
- Reset asserted mid-frame or mid-INIT: all state clears and INIT restarts; the table contents are rebuilt.

Optional Feature:
Macro GAMMA_LUT_READBACK_EN.
- Defined: adds ports cfg_ren (input, 1), cfg_rdata (output, BITS) and cfg_rvalid (output, 1).
  - cfg_ren in IDLE reads the shadow bank at cfg_chan/cfg_addr.
  - cfg_rvalid pulses exactly 2 cycles later, with data in cfg_rdata.
  - If cfg_wen and cfg_ren are both high, the write wins and the read is dropped (no cfg_rvalid).
  - Reads while busy are dropped.
  - Reset values: cfg_rdata=0, cfg_rvalid=0.
- Undefined: the ports and read logic are absent; all other behaviour is identical.

Test Plan:
- Reset, count cycles to init_done -> init_done rises exactly 256 cycles after reset release (LUT_BITS=8). cfg_busy is 1 throughout INIT. During INIT, in_data=0x55 in href passes through as 0x55 after 2 cycles.
- After init, drive pixel 0x80/0x40/0x10 with href -> out_data = identical values 2 cycles later; out_href and out_vsync are delayed by 2.
- Write channel 0 addr 0x80 = 0xBA, commit, then pixel 0x80 before vsync -> 0x80. After the vsync rising edge: bank_sel=1, output = 0xBA; channels 1 and 2 are unchanged.
- Commit coincident with a vsync rising edge -> no swap on that edge; swap on the following rising edge. cfg_wen during PENDING leaves the shadow table unchanged.
- Assert rst_n low mid-line after a swap -> outputs go to 0 immediately, bank_sel=0, and INIT reruns. Pixel 0x80 then maps to 0x80.
- GAMMA_LUT_READBACK_EN: write 0x3C to channel 2 addr 5, then read -> cfg_rvalid after 2 cycles with cfg_rdata=0x3C. Simultaneous wen+ren -> no cfg_rvalid.
